// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the FND scan controller slice.
package fnd_pkg;

   // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}, dp off.
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   // Largest value that fits on four decimal digits.
   localparam logic [13:0] MAX_DISPLAY = 14'd9999;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV   = 2'd1,
      ST_COMMIT = 2'd2
   } fnd_state_e;

   // BCD digit to segment pattern; non-decimal nibbles show blank.
   function automatic logic [7:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'd0:    seg_decode = SEG_0;
         4'd1:    seg_decode = SEG_1;
         4'd2:    seg_decode = SEG_2;
         4'd3:    seg_decode = SEG_3;
         4'd4:    seg_decode = SEG_4;
         4'd5:    seg_decode = SEG_5;
         4'd6:    seg_decode = SEG_6;
         4'd7:    seg_decode = SEG_7;
         4'd8:    seg_decode = SEG_8;
         4'd9:    seg_decode = SEG_9;
         default: seg_decode = SEG_BLANK;
      endcase
   endfunction

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
   function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
      bcd_adjust = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) bcd_adjust[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Load handshake between the status logic (master) and the FND controller (slave).
interface fnd_scan_controller_if;
   logic [13:0] i_value;
   logic        i_load;
   logic [3:0]  i_dp;
   logic        o_busy;

   modport master (output i_value, output i_load, output i_dp, input  o_busy);
   modport slave  (input  i_value, input  i_load, input  i_dp, output o_busy);
endinterface

// File: rtl/fnd_bin2bcd_seq.sv
// 14-bit sequential double-dabble: one adjust+shift per cycle, 14 cycles.
// o_done is high during the final shift cycle; o_bcd holds the result from
// the following cycle until the next start.
module fnd_bin2bcd_seq
   import fnd_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_start,
   input  logic [13:0] i_value,
   output logic        o_done,
   output logic [15:0] o_bcd
);

   logic [13:0] bin_r;
   logic [15:0] bcd_r;
   logic [15:0] bcd_adj;
   logic [3:0]  cnt_r;
   logic        act_r;

   // Correction applied before every shift.
   always_comb bcd_adj = bcd_adjust(bcd_r);

   // Shift engine and CONV cycle counter.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         bin_r <= '0;
         bcd_r <= '0;
         cnt_r <= '0;
         act_r <= 1'b0;
      end else if (i_start) begin
         bin_r <= i_value;
         bcd_r <= '0;
         cnt_r <= '0;
         act_r <= 1'b1;
      end else if (act_r) begin
         {bcd_r, bin_r} <= {bcd_adj[14:0], bin_r, 1'b0};
         cnt_r          <= cnt_r + 4'd1;
         if (cnt_r == 4'd13) act_r <= 1'b0;
      end
   end

   assign o_done = act_r && (cnt_r == 4'd13);
   assign o_bcd  = bcd_r;

endmodule

// File: rtl/fnd_scan_controller.sv
// FND scan controller: binary-to-BCD conversion with load queueing, atomic
// display commit, and a prescaled 4-digit active-low multiplexer.
module fnd_scan_controller
   import fnd_pkg::*;
#(
   parameter int SCAN_DIV = 100_000,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   fnd_scan_controller_if.slave        bus,
   output logic [3:0]                  o_fnd_digit,
   output logic [7:0]                  o_fnd_seg
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   fnd_state_e  state_r;
   logic        busy_r;
   logic [3:0]  work_dp_r;
   logic        work_ovf_r;
   logic [13:0] pend_val_r;
   logic [3:0]  pend_dp_r;
   logic        pend_r;
   logic [15:0] disp_bcd_r;
   logic [3:0]  disp_dp_r;
   logic        disp_ovf_r;

   logic        restart_req;
   logic [13:0] src_val;
   logic [3:0]  src_dp;
   logic        src_ovf;
   logic        core_start;
   logic        core_done;
   logic [15:0] core_bcd;

   // Next job source: a load this cycle beats anything already pending.
   always_comb begin
      restart_req = bus.i_load || pend_r;
      src_val     = bus.i_load ? bus.i_value : pend_val_r;
      src_dp      = bus.i_load ? bus.i_dp    : pend_dp_r;
      src_ovf     = src_val > MAX_DISPLAY;
      core_start  = (state_r == ST_IDLE || state_r == ST_COMMIT) && restart_req && !src_ovf;
   end

   fnd_bin2bcd_seq u_bin2bcd (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_start   (core_start),
      .i_value   (src_val),
      .o_done    (core_done),
      .o_bcd     (core_bcd)
   );

   // Conversion FSM: IDLE -> CONV (14) -> COMMIT (1); overflow goes straight to COMMIT.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r    <= ST_IDLE;
         busy_r     <= 1'b0;
         work_dp_r  <= '0;
         work_ovf_r <= 1'b0;
         pend_val_r <= '0;
         pend_dp_r  <= '0;
         pend_r     <= 1'b0;
         disp_bcd_r <= '0;
         disp_dp_r  <= '0;
         disp_ovf_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (restart_req) begin
                  work_dp_r  <= src_dp;
                  work_ovf_r <= src_ovf;
                  pend_r     <= 1'b0;
                  state_r    <= src_ovf ? ST_COMMIT : ST_CONV;
                  busy_r     <= 1'b1;
               end
            end
            ST_CONV: begin
               if (bus.i_load) begin
                  pend_val_r <= bus.i_value;
                  pend_dp_r  <= bus.i_dp;
                  pend_r     <= 1'b1;
               end
               if (core_done) state_r <= ST_COMMIT;
            end
            ST_COMMIT: begin
               disp_bcd_r <= work_ovf_r ? 16'h0000 : core_bcd;
               disp_dp_r  <= work_dp_r;
               disp_ovf_r <= work_ovf_r;
               if (restart_req) begin
                  // Chain straight into the next job so busy never drops.
                  work_dp_r  <= src_dp;
                  work_ovf_r <= src_ovf;
                  pend_r     <= 1'b0;
                  state_r    <= src_ovf ? ST_COMMIT : ST_CONV;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_busy = busy_r;

   logic [CW-1:0] scan_cnt_r;
   logic [1:0]    idx_r;
   logic          tick;
   logic [3:0]    lz;
   logic [3:0]    nib;
   logic [7:0]    seg_next;

   // Segment pattern for the digit about to be shown.
   always_comb begin
      tick     = (scan_cnt_r == CW'(SCAN_DIV - 1));
      nib      = disp_bcd_r[{idx_r, 2'b00} +: 4];
      lz[3]    = (disp_bcd_r[15:12] == 4'd0);
      lz[2]    = lz[3] && (disp_bcd_r[11:8] == 4'd0);
      lz[1]    = lz[2] && (disp_bcd_r[7:4]  == 4'd0);
      lz[0]    = 1'b0;
      if (disp_ovf_r)                seg_next = SEG_DASH;
      else if (BLANK_LZ && lz[idx_r]) seg_next = SEG_BLANK;
      else                           seg_next = seg_decode(nib);
      if (disp_dp_r[idx_r]) seg_next[7] = 1'b0;
   end

   // Scan prescaler; idx_r names the slot lit at the next tick, so digit 0 comes first.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         scan_cnt_r  <= '0;
         idx_r       <= 2'd0;
         o_fnd_digit <= 4'b1111;
         o_fnd_seg   <= SEG_BLANK;
      end else if (tick) begin
         scan_cnt_r  <= '0;
         idx_r       <= idx_r + 2'd1;
         o_fnd_digit <= ~(4'b0001 << idx_r);
         o_fnd_seg   <= seg_next;
      end else begin
         scan_cnt_r  <= scan_cnt_r + CW'(1);
      end
   end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with SCAN_DIV=4; a second instance
// runs with leading-zero blanking disabled on the same stimulus.
module tb_fnd_scan_controller;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fnd_scan_controller_if bus();
   fnd_scan_controller_if bus0();

   logic [3:0] dig, dig0;
   logic [7:0] seg, seg0;

   fnd_scan_controller #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .bus(bus.slave),
      .o_fnd_digit(dig), .o_fnd_seg(seg));

   fnd_scan_controller #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
      .i_clk(clk), .i_reset_n(rst_n), .bus(bus0.slave),
      .o_fnd_digit(dig0), .o_fnd_seg(seg0));

   int vec  = 0;
   int miss = 0;

   // Free-running observers; the stimulus takes differences across a test.
   int   busy_total = 0;
   int   busy_rises = 0;
   int   seen42     = 0;
   logic busy_d     = 1'b0;
   always @(negedge clk) begin
      if (bus.o_busy === 1'b1) busy_total <= busy_total + 1;
      if (bus.o_busy === 1'b1 && busy_d !== 1'b1) busy_rises <= busy_rises + 1;
      busy_d <= bus.o_busy;
      if ((dig == 4'b1110 && seg == 8'hA4) || (dig == 4'b1101 && seg == 8'h99))
         seen42 <= seen42 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [13:0] v, input logic [3:0] d);
      bus.i_value  = v; bus.i_dp  = d; bus.i_load  = 1'b1;
      bus0.i_value = v; bus0.i_dp = d; bus0.i_load = 1'b1;
      step();
      bus.i_load = 1'b0; bus0.i_load = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.o_busy === 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("idle_timeout", {31'd0, bus.o_busy}, 32'd0);
   endtask

   // Wait for a fresh appearance of a digit select, then check digit+segment.
   task automatic wait_dig(input bit sel0, input logic [3:0] pat, input logic [7:0] exp,
                           input string tag);
      logic [3:0] prev;
      int n = 0;
      do begin
         prev = sel0 ? dig0 : dig;
         step();
         n++;
      end while (!((sel0 ? dig0 : dig) == pat && prev != pat) && n < 40);
      chk(tag, {20'd0, (sel0 ? dig0 : dig), (sel0 ? seg0 : seg)}, {20'd0, pat, exp});
   endtask

   // Called #1 after the edge at which reset was released.
   task automatic chk_release(input string tag);
      for (int i = 0; i < 3; i++) begin
         step();
         chk({tag, "_dark"}, {20'd0, dig, seg}, {20'd0, 4'b1111, 8'hFF});
      end
      step();
      chk({tag, "_first"}, {20'd0, dig, seg}, {20'd0, 4'b1110, 8'hC0});
   endtask

   initial begin
      int b, r, s;
      bus.i_value  = '0; bus.i_dp  = '0; bus.i_load  = 1'b0;
      bus0.i_value = '0; bus0.i_dp = '0; bus0.i_load = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_digit", {28'd0, dig}, 32'hF);
      chk("rst_seg",   {24'd0, seg}, 32'hFF);
      chk("rst_busy",  {31'd0, bus.o_busy}, 32'd0);
      chk("rst_digit0", {28'd0, dig0}, 32'hF);

      // Release: dark for SCAN_DIV cycles, then digit 0 shows 0, others blank
      rst_n = 1'b1;
      chk_release("rel");
      wait_dig(1'b0, 4'b1101, 8'hFF, "rel_d1");
      wait_dig(1'b0, 4'b1011, 8'hFF, "rel_d2");
      wait_dig(1'b0, 4'b0111, 8'hFF, "rel_d3");

      // 1234 with dp on digit 2
      b = busy_total;
      load(14'd1234, 4'b0100);
      chk("busy_1234_start", {31'd0, bus.o_busy}, 32'd1);
      wait_idle();
      chk("busy_1234_len", busy_total - b, 32'd15);
      wait_dig(1'b0, 4'b1110, 8'h99, "v1234_d0");
      wait_dig(1'b0, 4'b1101, 8'hB0, "v1234_d1");
      wait_dig(1'b0, 4'b1011, 8'h24, "v1234_d2");
      wait_dig(1'b0, 4'b0111, 8'hF9, "v1234_d3");

      // 5: blanked leading zeros vs. full display
      load(14'd5, 4'b0000);
      wait_idle();
      wait_dig(1'b0, 4'b1110, 8'h92, "v5_d0");
      wait_dig(1'b0, 4'b1101, 8'hFF, "v5_d1");
      wait_dig(1'b0, 4'b1011, 8'hFF, "v5_d2");
      wait_dig(1'b0, 4'b0111, 8'hFF, "v5_d3");
      wait_dig(1'b1, 4'b1110, 8'h92, "v5nolz_d0");
      wait_dig(1'b1, 4'b1101, 8'hC0, "v5nolz_d1");
      wait_dig(1'b1, 4'b1011, 8'hC0, "v5nolz_d2");
      wait_dig(1'b1, 4'b0111, 8'hC0, "v5nolz_d3");

      // Overflow: one busy cycle, dashes everywhere
      b = busy_total;
      load(14'd10000, 4'b0000);
      wait_idle();
      chk("busy_ovf_len", busy_total - b, 32'd1);
      wait_dig(1'b0, 4'b1110, 8'hBF, "ovf_d0");
      wait_dig(1'b0, 4'b1101, 8'hBF, "ovf_d1");
      wait_dig(1'b0, 4'b1011, 8'hBF, "ovf_d2");
      wait_dig(1'b0, 4'b0111, 8'hBF, "ovf_d3");

      // 42, then 7 and 9 during CONV: 9 wins, busy continuous for 30 cycles
      b = busy_total; r = busy_rises; s = seen42;
      load(14'd42, 4'b0000);
      step(); step();
      load(14'd7, 4'b0000);
      step(); step();
      load(14'd9, 4'b0000);
      wait_idle();
      chk("busy_chain_len",   busy_total - b, 32'd30);
      chk("busy_chain_rises", busy_rises - r, 32'd1);
      chk("v42_visible",      {31'd0, seen42 > s}, 32'd1);
      wait_dig(1'b0, 4'b1110, 8'h90, "v9_d0");
      wait_dig(1'b0, 4'b1101, 8'hFF, "v9_d1");
      wait_dig(1'b0, 4'b0111, 8'hFF, "v9_d3");

      // Reset at CONV cycle 6 with a pending load
      load(14'd123, 4'b0000);
      load(14'd456, 4'b0000);
      repeat (4) step();
      rst_n = 1'b0;
      #2;
      chk("midrst_busy", {31'd0, bus.o_busy}, 32'd0);
      chk("midrst_out",  {20'd0, dig, seg}, {20'd0, 4'b1111, 8'hFF});
      step();
      rst_n = 1'b1;
      chk_release("rel2");
      b = busy_total;
      repeat (20) step();
      chk("rel2_no_resume", busy_total - b, 32'd0);
      wait_dig(1'b0, 4'b1101, 8'hFF, "rel2_d1");

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
- Consumer side of the FND clock chain. Accepts a binary value 0..9999 and converts it to BCD with a sequential double-dabble engine.
- Drives a 4-digit common-anode 7-segment display by time-multiplexing digits at a rate set by an internal scan prescaler.
- Single clock domain. The scan rate comes from an enable strobe, not a derived clock.
- Sits between the motor/PWM status logic and the board FND pins.

Parameters:
- SCAN_DIV, 100_000, i_clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range >= 2.
- BLANK_LZ, 1, 1 = blank leading zeros on digits 3..1; 0 = always show all digits.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  reset; asynchronous, active-low.
- i_value  in  14  binary value to display.
- i_load  in  1  one-cycle strobe; samples i_value and i_dp.
- i_dp  in  4  decimal point enable per digit (bit0 = ones digit), active-high.
- o_busy  out  1  conversion in progress.
- o_fnd_digit  out  4  digit select, active-low, bit0 = rightmost (ones).
- o_fnd_seg  out  8  segments, active-low, order {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset state, async on i_reset_n low:
  - o_fnd_digit = 4'b1111, o_fnd_seg = 8'hFF, o_busy = 0.
  - Display register = BCD 0000, dp = 0000, overflow flag = 0.
  - Scan counter = 0, digit index = 0, pending flag = 0, FSM = IDLE.
- Conversion FSM, states IDLE, CONV, COMMIT:
  - IDLE: i_load=1 captures i_value/i_dp into the work register, goes to CONV; o_busy=1 from the next cycle.
  - CONV: exactly 14 shift cycles of double-dabble (add 3 to any BCD nibble >= 5, then shift left). Then COMMIT.
  - COMMIT: one cycle. Writes the 4 BCD nibbles, dp and overflow flag into the display register atomically, then returns to IDLE.
  - o_busy is high for exactly 15 cycles per conversion (14 CONV + 1 COMMIT).
- Load while busy:
  - i_load=1 in CONV or COMMIT latches i_value/i_dp into a pending register and sets the pending flag.
  - Newest load wins; earlier pending values are overwritten.
  - COMMIT with pending=1 goes directly to CONV using the pending data and clears the flag. o_busy stays high with no gap.
- Overflow: i_value > 9999 skips CONV (COMMIT the next cycle, o_busy high for 1 cycle). Sets the overflow flag; all four digits show dash (8'hBF, dp per i_dp).
- Scan:
  - The counter counts 0..SCAN_DIV-1 and wraps. At terminal count it advances the digit index 0->1->2->3->0.
  - On the same edge, o_fnd_digit and o_fnd_seg are registered together for the new index. Digit and segment never mismatch for any cycle.
  - The first digit lights SCAN_DIV cycles after reset release. Digit 0 is selected first.
- Segment decode (dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90, blank=FF, dash=BF. dp on clears bit7.
- Leading-zero blank (BLANK_LZ=1):
  - Digit k (k=3..1) is blank if it and every higher digit are 0.
  - Digit 0 is never blanked.
  - The dp still shows on a blanked digit.
- Display register updates are not visible until the next scan tick. A commit mid-slot does not glitch the current outputs.
- Reset asserted mid-conversion aborts the conversion and drops pending; all state returns to reset values.

Decomposition:
- Shared package fnd_pkg:
  - segment code constants (SEG_0..SEG_9, SEG_BLANK, SEG_DASH).
  - FSM state encoding.
  - MAX_DISPLAY = 9999.
- One sub-module, fnd_bin2bcd_seq: the 14-bit sequential double-dabble core.
  - Interface: start/value in; done/bcd out.
  - Owns the CONV counter.
- The top holds the pending/commit logic, scan prescaler and decode.

Test Plan (SCAN_DIV=4 for sim):
- Reset release, no load -> digits 1111/FF for 4 cycles, then digit0 active (1110) with seg C0; digits 1..3 show FF when scanned.
- Load 1234, i_dp=0100 -> o_busy high 15 cycles. After commit, scan shows digit0=99, digit1=B0, digit2=24 (A4 with dp), digit3=F9.
- Load 5 with BLANK_LZ=1 -> digit0=92, digits1..3=FF. With BLANK_LZ=0 -> digits1..3=C0.
- Load 10000 -> o_busy exactly 1 cycle; all digits BF.
- Load 42, then load 7 and load 9 during CONV -> o_busy continuous for 30 cycles; final display digit0=90 with digits1..3 blank. 42 is visible in between.
- Assert i_reset_n=0 at CONV cycle 6 with a pending load -> outputs immediately 1111/FF, o_busy=0. After release, display shows 0 and no conversion resumes.
